mem_arbiter: RTL and testbench

- Sequences the single shared multi-cycle unified memory between two requesters: the instruction-fetch port (IF) and the data port (D).
- D requests come from the LW/SW decode path, i.e. MemRead/MemWrite from the control decoder.
- Owns the memory handshake: latches address and data, counts out the fixed memory latency, and returns read data with a one-cycle done pulse.
- The pipeline stalls on the stall outputs.

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Sequences the single shared, fixed-latency unified memory between the
// instruction-fetch requester (IF) and the data requester (D, from LW/SW).
// One transaction at a time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE.
// Arbitration alternates priority when both requesters are pending.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   if_req/if_addr        fetch request and address (held until if_done)
//   d_req/d_wr/d_addr     data request, store qualifier, address
//   d_wdata               store data
//   if_done/if_rdata      fetch completion pulse and fetched word
//   d_done/d_rdata        data completion pulse and loaded word
//   if_stall/d_stall      pipeline stall (req & ~done)
//   mem_en/mem_wr         one-cycle memory strobe and write qualifier
//   mem_addr/mem_wdata    latched address/data, stable ISSUE..DONE
//   mem_rdata             memory read data, valid MEM_LAT cycles after mem_en
//   busy                  high whenever a transaction is in flight
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              if_stall,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_t;

  // Counter is 4 bits wide, enough for the full legal latency range 1..15.
  localparam logic [3:0] LatCount = 4'(MEM_LAT);

  state_t            state_q,     state_d;
  logic [3:0]        cnt_q,       cnt_d;
  logic              ownerIsD_q,  ownerIsD_d;
  logic              lastIsD_q,   lastIsD_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic              wr_q,        wr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [DATA_W-1:0] ifRdata_q,   ifRdata_d;
  logic [DATA_W-1:0] dRdata_q,    dRdata_d;
  logic              grantD;

  // D wins when it is the only requester, or when both are pending and IF
  // was the previous owner; this gives strict alternation under contention.
  assign grantD = d_req & (~if_req | ~lastIsD_q);

  // State register: every piece of arbiter state, cleared together on reset
  // so an in-flight transaction is abandoned without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ownerIsD_q <= 1'b0;
      lastIsD_q  <= 1'b0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      ifRdata_q  <= '0;
      dRdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ownerIsD_q <= ownerIsD_d;
      lastIsD_q  <= lastIsD_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      ifRdata_q  <= ifRdata_d;
      dRdata_q   <= dRdata_d;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE; the transaction
  // parameters are latched on the grant and then ignored until the next IDLE.
  // The read result is captured on the last WAIT cycle into the owner's
  // register only, and never for stores.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ownerIsD_d = ownerIsD_q;
    lastIsD_d  = lastIsD_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    ifRdata_d  = ifRdata_q;
    dRdata_d   = dRdata_q;
    case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          state_d    = StIssue;
          cnt_d      = '0;
          ownerIsD_d = grantD;
          lastIsD_d  = grantD;
          addr_d     = grantD ? d_addr : if_addr;
          wr_d       = grantD & d_wr;
          wdata_d    = grantD ? d_wdata : '0;
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = 4'd1;
      end
      StWait: begin
        if (cnt_q == LatCount) begin
          state_d = StDone;
          if (!ownerIsD_q) begin
            ifRdata_d = mem_rdata;
          end else if (!wr_q) begin
            dRdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output logic: strobes and done pulses decode straight from the state so
  // they can only ever appear in ISSUE and DONE respectively. Stalls are
  // combinational so they drop in the same cycle as done.
  always_comb begin
    mem_en   = (state_q == StIssue);
    if_done  = (state_q == StDone) & ~ownerIsD_q;
    d_done   = (state_q == StDone) & ownerIsD_q;
    busy     = (state_q != StIdle);
    if_stall = if_req & ~if_done;
    d_stall  = d_req & ~d_done;
    mem_wr    = wr_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_rdata  = ifRdata_q;
    d_rdata   = dRdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with MEM_LAT=4. A behavioural memory drives
// mem_rdata exactly MEM_LAT cycles after each mem_en cycle; it returns
// addr ^ 16'h5A5A except for address 16'h0010, which returns 16'hB123.
// Outside that single valid cycle the memory drives 16'hDEAD.
module tb_mem_arbiter;

  localparam int MemLat = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        if_done;
  logic [15:0] if_rdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        if_stall;
  logic        d_stall;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .ADDR_W (16),
    .DATA_W (16),
    .MEM_LAT(MemLat)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .d_req    (d_req),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .if_stall (if_stall),
    .d_stall  (d_stall),
    .mem_en   (mem_en),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  function automatic logic [15:0] tbMemWord(input logic [15:0] a);
    if (a == 16'h0010) return 16'hB123;
    return a ^ 16'h5A5A;
  endfunction

  // Memory model: on the negedge of the mem_en cycle start a countdown, and
  // present the word during the cycle MEM_LAT cycles later. Reset discards it.
  int          memCnt = 0;
  logic [15:0] memLatAddr = '0;
  always @(negedge clk) begin
    if (rst) begin
      memCnt    = 0;
      mem_rdata = 16'hDEAD;
    end else begin
      mem_rdata = 16'hDEAD;
      if (memCnt > 0) begin
        memCnt = memCnt - 1;
        if (memCnt == 0) mem_rdata = tbMemWord(memLatAddr);
      end
      if (mem_en) begin
        memLatAddr = mem_addr;
        memCnt     = MemLat;
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        ifReq;
    logic [15:0] ifAddr;
    logic        dReq;
    logic        dWr;
    logic [15:0] dAddr;
    logic [15:0] dWdata;
    logic        eIfDone;
    logic [15:0] eIfRdata;
    logic        eDDone;
    logic [15:0] eDRdata;
    logic        eMemEn;
    logic        chkMem;
    logic        eMemWr;
    logic [15:0] eMemAddr;
    logic [15:0] eMemWdata;
    logic        eBusy;
  } vec_t;

  vec_t vecs[$];

  task automatic addV(input logic r, input logic ir, input logic [15:0] ia,
                      input logic dr, input logic dw, input logic [15:0] da,
                      input logic [15:0] dwd, input logic eid,
                      input logic [15:0] eir, input logic edd,
                      input logic [15:0] edr, input logic een, input logic cm,
                      input logic ewr, input logic [15:0] ea,
                      input logic [15:0] ewd, input logic eb);
    vec_t v;
    v.rst = r; v.ifReq = ir; v.ifAddr = ia; v.dReq = dr; v.dWr = dw;
    v.dAddr = da; v.dWdata = dwd; v.eIfDone = eid; v.eIfRdata = eir;
    v.eDDone = edd; v.eDRdata = edr; v.eMemEn = een; v.chkMem = cm;
    v.eMemWr = ewr; v.eMemAddr = ea; v.eMemWdata = ewd; v.eBusy = eb;
    vecs.push_back(v);
  endtask

  task automatic checkVal(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst     = v.rst;
    if_req  = v.ifReq;
    if_addr = v.ifAddr;
    d_req   = v.dReq;
    d_wr    = v.dWr;
    d_addr  = v.dAddr;
    d_wdata = v.dWdata;
  endtask

  task automatic checkOutput(input int row, input vec_t v);
    string p;
    p = $sformatf("row%0d", row);
    checkVal({p, " if_done"},  32'(if_done),  32'(v.eIfDone));
    checkVal({p, " if_rdata"}, 32'(if_rdata), 32'(v.eIfRdata));
    checkVal({p, " d_done"},   32'(d_done),   32'(v.eDDone));
    checkVal({p, " d_rdata"},  32'(d_rdata),  32'(v.eDRdata));
    checkVal({p, " mem_en"},   32'(mem_en),   32'(v.eMemEn));
    checkVal({p, " busy"},     32'(busy),     32'(v.eBusy));
    checkVal({p, " if_stall"}, 32'(if_stall), 32'(v.ifReq & ~v.eIfDone));
    checkVal({p, " d_stall"},  32'(d_stall),  32'(v.dReq & ~v.eDDone));
    if (v.chkMem) begin
      checkVal({p, " mem_wr"},    32'(mem_wr),    32'(v.eMemWr));
      checkVal({p, " mem_addr"},  32'(mem_addr),  32'(v.eMemAddr));
      checkVal({p, " mem_wdata"}, 32'(mem_wdata), 32'(v.eMemWdata));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0;
  endtask

  // Leaves the bench just after the edge that applied reset (cycle 0).
  task automatic applyReset();
    step();
    rst = 1'b1;
    idleInputs();
    step();
    rst = 1'b0;
  endtask

  // Counts cycles after the current one until the selected done pulse.
  // Returns -1 when the budget runs out.
  task automatic waitDone(input bit isD, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      @(negedge clk);
      if ((isD && d_done) || (!isD && if_done)) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;

    // Row 0: reset state.
    addV(0,0,16'h0,0,0,16'h0,16'h0, 0,16'h0,0,16'h0, 0,1,0,16'h0,16'h0, 0);
    // Single fetch of 0x0010.
    addV(0,1,16'h10,0,0,16'h0,16'h0, 0,16'h0,0,16'h0, 0,1,0,16'h0,16'h0, 0);
    addV(0,1,16'h10,0,0,16'h0,16'h0, 0,16'h0,0,16'h0, 1,1,0,16'h10,16'h0, 1);
    for (int i = 0; i < 4; i++)
      addV(0,1,16'h10,0,0,16'h0,16'h0, 0,16'h0,0,16'h0, 0,1,0,16'h10,16'h0, 1);
    addV(0,1,16'h10,0,0,16'h0,16'h0, 1,16'hB123,0,16'h0, 0,1,0,16'h10,16'h0, 1);
    addV(0,0,16'h0,0,0,16'h0,16'h0, 0,16'hB123,0,16'h0, 0,0,0,16'h0,16'h0, 0);
    // Store 0x1234 to 0x8000: d_rdata must stay 0.
    addV(0,0,16'h0,1,1,16'h8000,16'h1234, 0,16'hB123,0,16'h0, 0,0,0,16'h0,16'h0, 0);
    addV(0,0,16'h0,1,1,16'h8000,16'h1234, 0,16'hB123,0,16'h0, 1,1,1,16'h8000,16'h1234, 1);
    for (int i = 0; i < 4; i++)
      addV(0,0,16'h0,1,1,16'h8000,16'h1234, 0,16'hB123,0,16'h0, 0,1,1,16'h8000,16'h1234, 1);
    addV(0,0,16'h0,1,1,16'h8000,16'h1234, 0,16'hB123,1,16'h0, 0,1,1,16'h8000,16'h1234, 1);
    addV(0,0,16'h0,0,0,16'h0,16'h0, 0,16'hB123,0,16'h0, 0,0,0,16'h0,16'h0, 0);
    // Reset between scenarios; if_rdata still visible in this row.
    addV(1,0,16'h0,0,0,16'h0,16'h0, 0,16'hB123,0,16'h0, 0,0,0,16'h0,16'h0, 0);
    // Simultaneous IF(0x20) and D load(0x30) after reset: D goes first.
    addV(0,1,16'h20,1,0,16'h30,16'h0, 0,16'h0,0,16'h0, 0,1,0,16'h0,16'h0, 0);
    addV(0,1,16'h20,1,0,16'h30,16'h0, 0,16'h0,0,16'h0, 1,1,0,16'h30,16'h0, 1);
    for (int i = 0; i < 4; i++)
      addV(0,1,16'h20,1,0,16'h30,16'h0, 0,16'h0,0,16'h0, 0,1,0,16'h30,16'h0, 1);
    addV(0,1,16'h20,1,0,16'h30,16'h0, 0,16'h0,1,16'h5A6A, 0,1,0,16'h30,16'h0, 1);
    addV(0,1,16'h20,0,0,16'h0,16'h0, 0,16'h0,0,16'h5A6A, 0,0,0,16'h0,16'h0, 0);
    addV(0,1,16'h20,0,0,16'h0,16'h0, 0,16'h0,0,16'h5A6A, 1,1,0,16'h20,16'h0, 1);
    for (int i = 0; i < 4; i++)
      addV(0,1,16'h20,0,0,16'h0,16'h0, 0,16'h0,0,16'h5A6A, 0,1,0,16'h20,16'h0, 1);
    addV(0,1,16'h20,0,0,16'h0,16'h0, 1,16'h5A7A,0,16'h5A6A, 0,1,0,16'h20,16'h0, 1);
    addV(0,0,16'h0,0,0,16'h0,16'h0, 0,16'h5A7A,0,16'h5A6A, 0,0,0,16'h0,16'h0, 0);

    rst = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);

    foreach (vecs[r]) begin
      step();
      applyStimulus(vecs[r]);
      @(negedge clk);
      checkOutput(r, vecs[r]);
    end

    // Fairness: D keeps requesting right after its done while IF waits.
    applyReset();
    if_req = 1'b1; if_addr = 16'h0020;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0030;
    waitDone(1'b1, 20, cyc);
    checkVal("fair d_latency", 32'(cyc), 32'd6);
    checkVal("fair d_rdata", 32'(d_rdata), 32'h5A6A);
    step();
    d_addr = 16'h0040;
    step();
    @(negedge clk);
    checkVal("fair if_granted_en", 32'(mem_en), 32'd1);
    checkVal("fair if_granted_addr", 32'(mem_addr), 32'h0020);
    checkVal("fair d_stall_waiting", 32'(d_stall), 32'd1);
    waitDone(1'b0, 20, cyc);
    checkVal("fair if_latency", 32'(cyc), 32'd5);
    checkVal("fair if_rdata", 32'(if_rdata), 32'h5A7A);
    step();
    if_req = 1'b0;
    step();
    @(negedge clk);
    checkVal("fair d2_en", 32'(mem_en), 32'd1);
    checkVal("fair d2_addr", 32'(mem_addr), 32'h0040);
    waitDone(1'b1, 20, cyc);
    checkVal("fair d2_latency", 32'(cyc), 32'd5);
    checkVal("fair d2_rdata", 32'(d_rdata), 32'h5A1A);
    step();
    d_req = 1'b0;

    // Request dropped mid-transaction still completes.
    applyReset();
    if_req = 1'b1; if_addr = 16'h0010;
    step();
    step();
    if_req = 1'b0;
    if_addr = 16'h7777;
    @(negedge clk);
    checkVal("drop if_stall_low", 32'(if_stall), 32'd0);
    checkVal("drop busy", 32'(busy), 32'd1);
    waitDone(1'b0, 12, cyc);
    checkVal("drop if_latency", 32'(cyc), 32'd4);
    checkVal("drop if_rdata", 32'(if_rdata), 32'hB123);

    // Reset in cycle 3 of a load: abandoned, then a fresh load completes.
    applyReset();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0030;
    step();
    step();
    step();
    rst = 1'b1;
    d_req = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    checkVal("rstmid busy", 32'(busy), 32'd0);
    checkVal("rstmid mem_en", 32'(mem_en), 32'd0);
    checkVal("rstmid mem_addr", 32'(mem_addr), 32'h0);
    checkVal("rstmid d_rdata", 32'(d_rdata), 32'h0);
    checkVal("rstmid if_rdata", 32'(if_rdata), 32'h0);
    checkVal("rstmid d_done", 32'(d_done), 32'd0);
    waitDone(1'b1, 8, cyc);
    checkVal("rstmid no_done", 32'(cyc), 32'hFFFF_FFFF);
    step();
    d_req = 1'b1; d_addr = 16'h0050;
    waitDone(1'b1, 20, cyc);
    checkVal("rstmid new_latency", 32'(cyc), 32'd6);
    checkVal("rstmid new_rdata", 32'(d_rdata), 32'h5A0A);
    step();
    d_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
